// File: rtl/spi_single_clk_pkg.sv
// Shared constants for the single-clock SPI slave: word width, counter width, frame byte slots.
// Pure definitions, no logic.
package spi_single_clk_pkg;
  localparam int BYTE_W_DEF = 8;
  localparam int CTR_W      = 6;

  localparam int IDX_ADDR  = 0;
  localparam int IDX_DATA0 = 1;
  localparam int IDX_DATA1 = 2;
endpackage

// File: rtl/spi_single_clk_if.sv
// Pad and register-file side signals of the SPI slave; slave = the block, master = its user.
// Plain bundle, no logic.
interface spi_single_clk_if import spi_single_clk_pkg::*; #(
  parameter int BYTE_W = BYTE_W_DEF
);
  logic              csn_pad;
  logic              sck_pad;
  logic              mosi_pad;
  logic              miso_pad;
  logic              spi_dreq;
  logic              spi_data_written;
  logic [BYTE_W-1:0] spi_data_to_send;
  logic [BYTE_W-1:0] spi_address_rx;
  logic              spi_address_rx_valid;
  logic [BYTE_W-1:0] spi_data_byte_0_rx;
  logic [BYTE_W-1:0] spi_data_byte_1_rx;
  logic              spi_data_byte_rx_valid;
  logic              valid_read;
  logic [CTR_W-1:0]  byte_ctr;

  modport slave (
    input  csn_pad, sck_pad, mosi_pad, spi_data_written, spi_data_to_send,
    output miso_pad, spi_dreq, spi_address_rx, spi_address_rx_valid,
           spi_data_byte_0_rx, spi_data_byte_1_rx, spi_data_byte_rx_valid,
           valid_read, byte_ctr
  );

  modport master (
    output csn_pad, sck_pad, mosi_pad, spi_data_written, spi_data_to_send,
    input  miso_pad, spi_dreq, spi_address_rx, spi_address_rx_valid,
           spi_data_byte_0_rx, spi_data_byte_1_rx, spi_data_byte_rx_valid,
           valid_read, byte_ctr
  );
endinterface

// File: rtl/spi_single_clk_pad_sync_edge.sv
// 3-stage pad synchroniser with registered rise/fall pulses; pulses lag the pad by 3 cycles.
// Level output is the third stage, aligned with the pulses so sampled data matches the edge.
module pad_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s3   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= pad;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  assign lvl = s3;
endmodule

// File: rtl/spi_single_clk.sv
// Mode-0 SPI slave sampled entirely in sys_clk: outputs update 1 cycle after the 8th SCK rise,
// valid_read 1 cycle later, spi_dreq 2 cycles after that; no backpressure, TX byte must arrive before next SCK fall.
module spi_single_clk import spi_single_clk_pkg::*; #(
  parameter int BYTE_W = BYTE_W_DEF
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  spi_single_clk_if.slave   bus
);
  localparam int CNT_W = $clog2(BYTE_W);

  logic csn_lvl, csn_rise, csn_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  pad_sync_edge #(.RST_VAL(1'b1)) u_csn (
    .clk(sys_clk), .rst_n(sys_rst_n), .pad(bus.csn_pad),
    .lvl(csn_lvl), .rise(csn_rise), .fall(csn_fall)
  );
  pad_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(sys_clk), .rst_n(sys_rst_n), .pad(bus.sck_pad),
    .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  pad_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(sys_clk), .rst_n(sys_rst_n), .pad(bus.mosi_pad),
    .lvl(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign unused_sync = &{1'b0, sck_lvl, mosi_rise, mosi_fall};

  logic [1:0]        flush_cnt;
  logic              armed;
  logic              active;
  logic              load_pend;
  logic              byte_done;
  logic              vr_d1;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] rx_sr, tx_sr, tx_hold, rx_next;
  logic              last_bit;
  logic [CTR_W:0]    frame_idx;

  assign rx_next   = {rx_sr[BYTE_W-2:0], mosi_lvl};
  assign last_bit  = (bit_cnt == CNT_W'(BYTE_W - 1));
  assign frame_idx = bus.spi_address_rx_valid ? ({1'b0, bus.byte_ctr} + 1'b1) : '0;
  assign bus.miso_pad = active & tx_sr[BYTE_W-1];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      flush_cnt                  <= '0;
      armed                      <= 1'b0;
      active                     <= 1'b0;
      load_pend                  <= 1'b0;
      byte_done                  <= 1'b0;
      vr_d1                      <= 1'b0;
      bit_cnt                    <= '0;
      rx_sr                      <= '0;
      tx_sr                      <= '0;
      tx_hold                    <= '0;
      bus.valid_read             <= 1'b0;
      bus.spi_dreq               <= 1'b0;
      bus.spi_address_rx         <= '0;
      bus.spi_address_rx_valid   <= 1'b0;
      bus.spi_data_byte_0_rx     <= '0;
      bus.spi_data_byte_1_rx     <= '0;
      bus.spi_data_byte_rx_valid <= 1'b0;
      bus.byte_ctr               <= '0;
    end else begin
      byte_done      <= 1'b0;
      bus.valid_read <= byte_done;
      vr_d1          <= bus.valid_read;
      bus.spi_dreq   <= vr_d1;

      // Only accept a frame once real pad samples show CSN idle; a reset mid-frame stays deaf until then.
      if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
      else if (csn_lvl)      armed     <= 1'b1;

      if (bus.spi_data_written) tx_hold <= bus.spi_data_to_send;

      if (csn_rise) begin
        active                     <= 1'b0;
        bus.spi_address_rx_valid   <= 1'b0;
        bus.spi_data_byte_rx_valid <= 1'b0;
      end else if (csn_fall && armed) begin
        active                     <= 1'b1;
        bit_cnt                    <= '0;
        load_pend                  <= 1'b0;
        tx_sr                      <= tx_hold;
        bus.byte_ctr               <= '0;
        bus.spi_address_rx_valid   <= 1'b0;
        bus.spi_data_byte_rx_valid <= 1'b0;
      end else if (active) begin
        if (sck_rise) begin
          rx_sr   <= rx_next;
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          if (last_bit) begin
            byte_done <= 1'b1;
            load_pend <= 1'b1;
            if (frame_idx == (CTR_W+1)'(IDX_ADDR)) begin
              bus.spi_address_rx       <= rx_next;
              bus.spi_address_rx_valid <= 1'b1;
            end else if (frame_idx == (CTR_W+1)'(IDX_DATA0)) begin
              bus.spi_data_byte_0_rx <= rx_next;
              bus.byte_ctr           <= CTR_W'(IDX_DATA0);
            end else if (frame_idx == (CTR_W+1)'(IDX_DATA1)) begin
              bus.spi_data_byte_1_rx     <= rx_next;
              bus.spi_data_byte_rx_valid <= 1'b1;
              bus.byte_ctr               <= CTR_W'(IDX_DATA1);
            end else if (bus.byte_ctr != '1) begin
              bus.byte_ctr <= bus.byte_ctr + 1'b1;
            end
          end
        end
        if (sck_fall) begin
          if (load_pend) begin
            tx_sr     <= tx_hold;
            load_pend <= 1'b0;
          end else begin
            tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_single_clk.sv
// Scoreboard bench for spi_single_clk: expected bytes queued as they are shifted in,
// compared whenever the DUT pulses valid_read; TX replies come from a response queue.
module tb_spi_single_clk;
  import spi_single_clk_pkg::*;

  localparam int HALF = 80;  // SCK half period = 8 sys_clk cycles

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  spi_single_clk_if #(.BYTE_W(8)) bus();
  spi_single_clk #(.BYTE_W(8)) dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));

  assign bus.spi_data_written = bus.spi_dreq;

  typedef struct {
    int         kind;
    logic [7:0] val;
    logic [5:0] ctr;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] resp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  int         vr_cnt = 0;
  bit         adv_pend = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard compare on valid_read, plus response queue advance after each captured request.
  always @(negedge sys_clk) begin
    if (bus.valid_read === 1'b1) begin
      vr_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("vr_unexpected", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("sb_byte_ctr", bus.byte_ctr, mon_e.ctr);
        case (mon_e.kind)
          0: begin
            check_eq("sb_addr", bus.spi_address_rx, mon_e.val);
            check_eq("sb_addr_valid", bus.spi_address_rx_valid, 1);
          end
          1: check_eq("sb_data0", bus.spi_data_byte_0_rx, mon_e.val);
          2: begin
            check_eq("sb_data1", bus.spi_data_byte_1_rx, mon_e.val);
            check_eq("sb_data_valid", bus.spi_data_byte_rx_valid, 1);
          end
          default: ;
        endcase
      end
    end
    if (adv_pend) begin
      if (resp_q.size() > 0) void'(resp_q.pop_front());
      adv_pend = 1'b0;
    end
    if (bus.spi_dreq === 1'b1) adv_pend = 1'b1;
    bus.spi_data_to_send = (resp_q.size() > 0) ? resp_q[0] : 8'h00;
  end

  task automatic push_exp(input int pos, input logic [7:0] v);
    exp_t e;
    e.kind = (pos <= 2) ? pos : 3;
    e.val  = v;
    e.ctr  = (pos == 0) ? 6'd0 : ((pos > 63) ? 6'd63 : 6'(pos));
    sb_q.push_back(e);
  endtask

  task automatic spi_bits(input logic [7:0] d, input int nbits,
                          output logic [7:0] m_rise, output logic [7:0] m_late);
    m_rise = '0;
    m_late = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi_pad = d[7-i];
      #(HALF);
      m_rise[7-i] = bus.miso_pad;
      bus.sck_pad = 1'b1;
      #40;
      m_late[7-i] = bus.miso_pad;
      #(HALF-40);
      bus.sck_pad = 1'b0;
    end
  endtask

  task automatic send_byte(input int pos, input logic [7:0] d,
                           output logic [7:0] m_rise, output logic [7:0] m_late);
    push_exp(pos, d);
    spi_bits(d, 8, m_rise, m_late);
  endtask

  task automatic csn_low();
    bus.csn_pad = 1'b0;
    #100;
  endtask

  task automatic csn_high();
    #100;
    bus.csn_pad = 1'b1;
    #100;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] mr, ml;
    logic [7:0] lb[70];
    logic [7:0] wb[3];

    bus.csn_pad  = 1'b1;
    bus.sck_pad  = 1'b0;
    bus.mosi_pad = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("reset_outs",
             {bus.spi_address_rx, bus.spi_address_rx_valid, bus.spi_data_byte_0_rx,
              bus.spi_data_byte_1_rx, bus.spi_data_byte_rx_valid, bus.valid_read,
              bus.spi_dreq, bus.byte_ctr, bus.miso_pad}, 0);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);

    // Write frame
    wb = '{8'h80, 8'h12, 8'h34};
    vr_cnt = 0;
    csn_low();
    for (int p = 0; p < 3; p++) send_byte(p, wb[p], mr, ml);
    #100;
    check_eq("wr_addr", bus.spi_address_rx, 8'h80);
    check_eq("wr_addr_valid", bus.spi_address_rx_valid, 1);
    check_eq("wr_data0", bus.spi_data_byte_0_rx, 8'h12);
    check_eq("wr_data1", bus.spi_data_byte_1_rx, 8'h34);
    check_eq("wr_data_valid", bus.spi_data_byte_rx_valid, 1);
    csn_high();
    check_eq("wr_vr_count", vr_cnt, 3);
    check_eq("wr_valids_clr", {bus.spi_address_rx_valid, bus.spi_data_byte_rx_valid}, 0);

    // TX loopback
    resp_q.push_back(8'hA5);
    resp_q.push_back(8'h3C);
    csn_low();
    send_byte(0, 8'h01, mr, ml);
    send_byte(1, 8'h55, mr, ml);
    check_eq("miso_b2_rise", mr, 8'hA5);
    check_eq("miso_b2_hold", ml, 8'hA5);
    send_byte(2, 8'hAA, mr, ml);
    check_eq("miso_b3_rise", mr, 8'h3C);
    check_eq("miso_b3_hold", ml, 8'h3C);
    csn_high();

    // Abort mid data byte 1
    vr_cnt = 0;
    csn_low();
    send_byte(0, 8'h11, mr, ml);
    send_byte(1, 8'h22, mr, ml);
    spi_bits(8'hFF, 5, mr, ml);
    #30;
    bus.csn_pad = 1'b1;
    #200;
    check_eq("ab_vr_count", vr_cnt, 2);
    check_eq("ab_valids_clr", {bus.spi_address_rx_valid, bus.spi_data_byte_rx_valid}, 0);
    check_eq("ab_ctr_hold", bus.byte_ctr, 1);
    check_eq("ab_addr_hold", bus.spi_address_rx, 8'h11);
    csn_low();
    check_eq("ab_ctr_restart", bus.byte_ctr, 0);
    send_byte(0, 8'h9E, mr, ml);
    send_byte(1, 8'h47, mr, ml);
    send_byte(2, 8'hD2, mr, ml);
    csn_high();

    // Long frame
    csn_low();
    for (int p = 0; p < 70; p++) begin
      lb[p] = 8'($urandom_range(0, 255));
      send_byte(p, lb[p], mr, ml);
    end
    #100;
    check_eq("long_ctr_sat", bus.byte_ctr, 63);
    check_eq("long_addr", bus.spi_address_rx, lb[0]);
    check_eq("long_data0", bus.spi_data_byte_0_rx, lb[1]);
    check_eq("long_data1", bus.spi_data_byte_1_rx, lb[2]);
    csn_high();
    check_eq("long_ctr_held", bus.byte_ctr, 63);

    // Reset mid-byte
    csn_low();
    send_byte(0, 8'hC3, mr, ml);
    spi_bits(8'h5A, 3, mr, ml);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_eq("rst_outs",
             {bus.spi_address_rx, bus.spi_address_rx_valid, bus.spi_data_byte_0_rx,
              bus.spi_data_byte_1_rx, bus.spi_data_byte_rx_valid, bus.valid_read,
              bus.spi_dreq, bus.byte_ctr}, 0);
    check_eq("rst_miso", bus.miso_pad, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    spi_bits(8'h5A, 5, mr, ml);
    spi_bits(8'hE7, 8, mr, ml);
    #100;
    check_eq("rst_ignore_valid", bus.spi_address_rx_valid, 0);
    check_eq("rst_ignore_miso", bus.miso_pad, 0);
    csn_high();
    csn_low();
    send_byte(0, 8'h42, mr, ml);
    send_byte(1, 8'h17, mr, ml);
    send_byte(2, 8'hB9, mr, ml);
    #100;
    check_eq("post_rst_addr", bus.spi_address_rx, 8'h42);
    check_eq("post_rst_data1", bus.spi_data_byte_1_rx, 8'hB9);
    csn_high();

    repeat (10) @(negedge sys_clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_single_clk.md
# spi_single_clk

Mode-0 SPI slave front end that runs entirely in the `sys_clk` domain, so no logic is clocked by `SCK`. It synchronises the raw pads, deserialises an address byte and two data bytes per frame, and reports each completed byte to a register-file state machine. It serialises a byte supplied through a request/acknowledge handshake back out on MISO.

## Interface
Parameters:
- `BYTE_W`, default 8: SPI word width in bits.

Ports:
- `sys_clk`, in, 1: system clock. One clock; every register in the block is clocked by it.
- `sys_rst_n`, in, 1: reset, synchronous, active-low.
- `csn_pad`, in, 1: raw chip select, active-low, asynchronous to `sys_clk`.
- `sck_pad`, in, 1: raw SPI clock, asynchronous to `sys_clk`.
- `mosi_pad`, in, 1: raw serial data in.
- `miso_pad`, out, 1: serial data out.
- `spi_dreq`, out, 1: one-cycle pulse requesting the next TX byte.
- `spi_data_written`, in, 1: high for one or more cycles when `spi_data_to_send` is valid. It may be tied to `spi_dreq`.
- `spi_data_to_send`, in, BYTE_W: next TX byte.
- `spi_address_rx`, out, BYTE_W: first byte of the frame.
- `spi_address_rx_valid`, out, 1: the address byte of the current frame has been received.
- `spi_data_byte_0_rx`, out, BYTE_W: second byte of the frame.
- `spi_data_byte_1_rx`, out, BYTE_W: third byte of the frame.
- `spi_data_byte_rx_valid`, out, 1: both data bytes have been received.
- `valid_read`, out, 1: one-cycle pulse on each completed byte.
- `byte_ctr`, out, 6: count of completed bytes after the address byte.

## Operation
- **Input synchronisation.** `csn_pad`, `sck_pad` and `mosi_pad` each pass through a 2-FF synchroniser, followed by a third stage that feeds the edge detectors. Rising and falling SCK edges and the CSN falling and rising edges are derived from the synchronised signals.
- **Frame start (CSN fall).**
  - Clear the bit counter, `byte_ctr`, `spi_address_rx_valid` and `spi_data_byte_rx_valid`.
  - Load the TX shift register from the TX holding register.
- **Receive.** Mode 0, MSB first. On each SCK rise while CSN is low, shift the synchronised MOSI into the RX shift register and increment the 3-bit bit counter.
- **Byte completion.** On the 8th SCK rise:
  - Frame byte 0: latch `spi_address_rx`, set `spi_address_rx_valid`, and `byte_ctr` stays 0.
  - Frame byte 1: latch `spi_data_byte_0_rx` and set `byte_ctr` to 1.
  - Frame byte 2: latch `spi_data_byte_1_rx`, set `spi_data_byte_rx_valid`, and set `byte_ctr` to 2.
  - Frame bytes 3 and later: discard the data and increment `byte_ctr`, saturating at 63.
  - For every byte, pulse `valid_read` in the cycle after the outputs update.
- **TX handshake.**
  - Two cycles after each `valid_read` pulse, pulse `spi_dreq` for one cycle.
  - Any cycle with `spi_data_written` high captures `spi_data_to_send` into the TX holding register.
  - On the first SCK fall after a byte completes, load the holding register into the TX shift register. On every other SCK fall within a byte, shift left.
  - `miso_pad` equals the shift register MSB while CSN is low, and 0 while CSN is high.
- **Frame end (CSN rise).**
  - Abort any partial byte. It produces no `valid_read` and no output update.
  - Clear both valid flags.
  - Hold the address and data outputs, and `byte_ctr`, at their last values.
- **Reset values.** All outputs 0, both holding registers 0, the synchroniser stages reset to idle (CSN=1, SCK=0), and `miso_pad` = 0.

## Timing
- Latency from a pad edge to its internal edge pulse is 3 `sys_clk` cycles.
- The data output and its valid flag update 1 cycle after the 8th SCK rise is detected. `valid_read` follows 1 cycle later, and `spi_dreq` 2 cycles after that.
- The SCK high time and low time must each be at least 4 `sys_clk` cycles.
- The interval from the 8th SCK rise to the next SCK fall must be at least 6 `sys_clk` cycles. This lets the requester answer `spi_dreq` and still have the byte loaded onto MISO.
- CSN setup before the first SCK rise must be at least 4 `sys_clk` cycles.
- If the CSN rise and an SCK edge fall in the same cycle, CSN wins.
- If `sys_rst_n` goes low mid-frame, the block returns to idle on the next clock edge. It ignores the rest of the frame until CSN is seen high and then low again.

## Structure
- Shared package: the `BYTE_W` default, the `byte_ctr` width (6), and the frame byte indices (ADDR=0, DATA0=1, DATA1=2).
- Sub-module `pad_sync_edge`: a 3-stage synchroniser with rise and fall pulse outputs. It is instantiated for CSN and SCK, with its synchronised level used for MOSI.
- The rest (RX/TX shifters, counters, handshake) is flat in `spi_single_clk`.

## Test plan
- **Write frame.** Send 0x80,0x12,0x34 with SCK at 1/16 of `sys_clk`.
  - Required: `spi_address_rx`=0x80 with valid, `spi_data_byte_0_rx`=0x12, `spi_data_byte_1_rx`=0x34, `spi_data_byte_rx_valid`=1.
  - Required: exactly 3 `valid_read` pulses, with `byte_ctr` at 0,1,2.
- **TX loopback.** Tie `spi_dreq` to `spi_data_written` and answer each request with 0xA5 then 0x3C.
  - Required: MISO bytes 2 and 3 read 0xA5 and 0x3C, MSB first, stable at each SCK rise.
- **Abort.** Drop CSN high after 5 bits of byte 1.
  - Required: no `valid_read` for the partial byte and both valid flags = 0.
  - Required: the next frame starts with `byte_ctr`=0.
- **Long frame.** Send a 70-byte frame.
  - Required: `byte_ctr` saturates at 63.
  - Required: the data outputs keep the bytes received at frame positions 1 and 2.
- **Reset.** Assert `sys_rst_n`=0 mid-byte.
  - Required: all outputs 0 the next cycle and `miso_pad`=0.
  - Required: a fresh frame afterwards decodes correctly.
